// File: rtl/bounce_gen_pkg.sv
// rtl/bounce_gen_pkg.sv - shared types and constants for the contact bounce emulator
package bounce_gen_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GLITCH_NEW,
        ST_GLITCH_OLD,
        ST_SETTLE
    } state_t;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR; a zero seed is replaced by 1
module lfsr16
    import bounce_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] value
);

    // An all-zero state would lock the register forever.
    localparam logic [LFSR_W-1:0] RESET_VAL = (SEED == '0) ? 16'h0001 : SEED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RESET_VAL;
        end else begin
            value <= {1'b0, value[LFSR_W-1:1]} ^ (value[0] ? LFSR_TAPS : '0);
        end
    end

endmodule

// File: rtl/bounce_gen.sv
// rtl/bounce_gen.sv - turns a clean button level into a bounded train of contact glitches
module bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter bit              RANDOM        = 1'b1,
    parameter int              BOUNCES_MAX   = 4,
    parameter int              GLITCH_W      = 3,
    parameter int              GLITCH_LEN    = 2,
    parameter int              SETTLE_CYCLES = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic btn_in,
    output logic btn_out,
    output logic busy,
    output logic done
);

    localparam int NW = $clog2(BOUNCES_MAX + 1);
    localparam int PW = GLITCH_W + 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    state_t            state;
    logic              target;
    logic [NW-1:0]     pair_cnt;
    logic [PW-1:0]     phase_cnt;
    logic [SW-1:0]     settle_cnt;
    logic [LFSR_W-1:0] lfsr;

    logic [7:0]        n_rand8;
    logic [NW-1:0]     n_load;
    logic [PW-1:0]     p_load;
    logic              unused_lfsr;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr)
    );

    assign n_rand8     = (lfsr[7:0] & 8'(BOUNCES_MAX - 1)) + 8'd1;
    assign n_load      = RANDOM ? NW'(n_rand8) : NW'(BOUNCES_MAX);
    assign p_load      = RANDOM ? ({1'b0, lfsr[LFSR_W-1 -: GLITCH_W]} + PW'(1)) : PW'(GLITCH_LEN);
    assign unused_lfsr = ^lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            target     <= 1'b0;
            btn_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pair_cnt   <= '0;
            phase_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (!enable) begin
                state      <= ST_IDLE;
                target     <= btn_in;
                btn_out    <= btn_in;
                busy       <= 1'b0;
                pair_cnt   <= '0;
                phase_cnt  <= '0;
                settle_cnt <= '0;
            end else if (btn_in != target) begin
                // New level, or an abort of the running train: btn_out and busy
                // are left alone so the first visible change lands one cycle later.
                target     <= btn_in;
                pair_cnt   <= n_load;
                phase_cnt  <= p_load;
                settle_cnt <= '0;
                state      <= ST_GLITCH_NEW;
            end else begin
                case (state)
                    ST_IDLE: begin
                        busy <= 1'b0;
                    end
                    ST_GLITCH_NEW: begin
                        btn_out <= target;
                        busy    <= 1'b1;
                        if (phase_cnt <= PW'(1)) begin
                            phase_cnt <= p_load;
                            state     <= ST_GLITCH_OLD;
                        end else begin
                            phase_cnt <= phase_cnt - PW'(1);
                        end
                    end
                    ST_GLITCH_OLD: begin
                        btn_out <= ~target;
                        busy    <= 1'b1;
                        if (phase_cnt <= PW'(1)) begin
                            pair_cnt <= (pair_cnt != '0) ? pair_cnt - NW'(1) : '0;
                            if (pair_cnt <= NW'(1)) begin
                                settle_cnt <= SW'(SETTLE_CYCLES);
                                state      <= ST_SETTLE;
                            end else begin
                                phase_cnt <= p_load;
                                state     <= ST_GLITCH_NEW;
                            end
                        end else begin
                            phase_cnt <= phase_cnt - PW'(1);
                        end
                    end
                    ST_SETTLE: begin
                        // The final edge to target happens on the first settle cycle.
                        if (settle_cnt != '0) begin
                            btn_out    <= target;
                            busy       <= 1'b1;
                            settle_cnt <= settle_cnt - SW'(1);
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/bounce_gen.md
# bounce_gen

Synthesizable mechanical-contact bounce emulator: converts a clean, same-clock button level into a bouncing waveform with bounded, pseudo-random or fixed glitch trains. It is the driving end of the button path. It sits in front of `debounce` for on-chip self-test and HIL rigs, and in benches as a reusable stimulus source.

## Interface
- `RANDOM`, 1: 1 = LFSR-driven bounce count and phase lengths; 0 = fixed pattern (directed test).
- `BOUNCES_MAX`, 4: max glitch pairs per transition. Must be a power of two when `RANDOM`=1. Must be ≥1.
- `GLITCH_W`, 3: random phase-length field width; phase = 1..2^GLITCH_W cycles.
- `GLITCH_LEN`, 2: fixed phase length in cycles (`RANDOM`=0). Must be ≥1.
- `SETTLE_CYCLES`, 8: stable cycles after the final edge before `done`. Must be ≥1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; 0 is replaced by 1.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  0 = bypass (`btn_out` follows `btn_in` registered, FSM held IDLE).
- `btn_in`  in  1  clean commanded level, synchronous to `clk`.
- `btn_out`  out  1  emulated bouncing contact.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse: output settled at target for `SETTLE_CYCLES`.

## Operation
- Registers: `target` (last accepted level), `btn_out`, 16-bit Galois LFSR with taps 16'hB400. The LFSR advances every cycle, including in bypass.
- FSM states: IDLE, GLITCH_NEW, GLITCH_OLD, SETTLE.
- IDLE: when `btn_in != target`:
  - `target <= btn_in`.
  - Load pair count N. `RANDOM`=1: N = 1 + (lfsr[7:0] & (BOUNCES_MAX-1)). `RANDOM`=0: N = BOUNCES_MAX.
  - Go to GLITCH_NEW.
- Phase length P is reloaded at every phase start. `RANDOM`=1: P = 1 + lfsr[15 -: GLITCH_W]. `RANDOM`=0: P = GLITCH_LEN.
- GLITCH_NEW: `btn_out = target` for P cycles, then go to GLITCH_OLD.
- GLITCH_OLD: `btn_out = ~target` for P cycles, then decrement N.
  - N reaches 0: drive `btn_out = target` and go to SETTLE.
  - Otherwise: go to GLITCH_NEW.
- SETTLE: `btn_out = target` for `SETTLE_CYCLES` cycles, then pulse `done` and go to IDLE.
- Every transition produces exactly 2N+1 edges on `btn_out`.
- `btn_in` change while GLITCH_* or SETTLE:
  - Abort the sequence; no `done` for it.
  - `target <= btn_in` and restart at GLITCH_NEW with a freshly loaded N.
  - If `btn_out` already equals the new target, the first GLITCH_NEW phase causes no edge.
- `enable` low:
  - FSM forced to IDLE, counters cleared, `busy`=`done`=0.
  - `btn_out <= btn_in` and `target <= btn_in` each cycle.
  - Re-enable causes no spurious sequence.
- Counter widths:
  - pair counter: $clog2(BOUNCES_MAX+1).
  - phase counter: GLITCH_W+1.
  - settle counter: $clog2(SETTLE_CYCLES+1).
  - No wrap is permitted; counters saturate at their load values.

## Timing
- Reset values: `btn_out`=0, `busy`=0, `done`=0, `target`=0, state IDLE, lfsr=`LFSR_SEED`.
- If `btn_in`=1 at reset release, a rising sequence starts on the first clock.
- Let `btn_in` differ from `target` at edge t (IDLE):
  - First `btn_out` change is visible after edge t+1 (latency 1).
  - `busy` rises with it.
- The final edge (to `target`) is followed by `SETTLE_CYCLES` stable cycles.
- `done` is high for the one cycle after those stable cycles, with `busy` already 0 in that cycle.
- A new `btn_in` change in the `done` cycle is accepted; the sequence starts the next cycle.
- All outputs are registered; no combinational input-to-output path.

## Structure
- `bounce_gen_pkg`: state enum (IDLE, GLITCH_NEW, GLITCH_OLD, SETTLE), `LFSR_TAPS` = 16'hB400, LFSR width constant 16.
- Sub-module `lfsr16`: seed parameter, `clk`/`rst_n`, 16-bit state out, zero-seed fixup.
- `bounce_gen`: FSM, counters, output register; instantiates `lfsr16`.

## Test plan
- Fixed mode, `RANDOM`=0, `BOUNCES_MAX`=3, `GLITCH_LEN`=2, `SETTLE_CYCLES`=8; `btn_in` 0->1 at cycle 0:
  - `btn_out` = 1 in cycles 1–2, 0 in 3–4, 1 in 5–6, 0 in 7–8, 1 in 9–10, 0 in 11–12, then 1 from cycle 13.
  - `busy` high in cycles 1–20; `done` high in cycle 21 only.
- Same configuration, falling 1->0 transition:
  - Mirror waveform: 7 edges, final level 0, `done` 21 cycles after the change.
- Abort: `btn_in` 0->1, then back to 0 at cycle 6:
  - No `done` for the rising transition.
  - A new 7-edge sequence toward 0 starts at cycle 7.
  - `done` in cycle 27, `btn_out` ends at 0.
- Bypass: `enable`=0, toggle `btn_in` every cycle:
  - `btn_out` equals `btn_in` delayed 1 cycle; `busy`=`done`=0.
  - Setting `enable`=1 with a static `btn_in` produces no activity.
- Random mode, `BOUNCES_MAX`=4, `GLITCH_W`=3, 200 random transitions:
  - Per transition: edge count odd and in 3..9, every phase length in 1..8 cycles, final level = `btn_in`.
  - Feeding `btn_out` into `debounce` yields exactly one `single_pulse_out` per rising transition.
- Reset mid-sequence: assert `rst_n` low during GLITCH_OLD:
  - `btn_out`, `busy` and `done` go to 0 immediately (asynchronously).
  - With `btn_in`=1 held, a fresh sequence starts on the first clock after release.
